// File: rtl/clk_div_pkg.sv
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared helpers for the multi-channel clock divider:
//                channel-select width derivation, high-time clamp and the
//                minimum legal divide ratio.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

    // Smallest period a channel can produce (one high cycle, one low cycle).
    localparam int c_MIN_DIV = 2;

    // Width of a channel-select field; never narrower than one bit so a
    // single-channel build still has a legal port.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A high time that would cover the whole period is pulled back to
    // div-1 so every period keeps at least one low cycle.
    function automatic logic [31:0] clamp_high(input logic [31:0] div,
                                               input logic [31:0] high);
        return (high >= div) ? (div - 32'd1) : high;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_chan.sv
// ============================================================================
//  Module      : clk_div_chan
//  Description : One divider channel. Counts 0..D-1, drives a registered
//                divided output (high while cnt < H) and a period-start tick.
//                New ratios wait in a shadow until the next period start.
//  Ports       : clock_in, reset   - clock / synchronous active-high reset
//                i_en              - run enable
//                i_sync            - restart at period start (when enabled)
//                i_wr              - accepted write addressed to this channel
//                i_wr_div/i_wr_high- new period and (already clamped) high time
//                o_clk_out, o_tick - registered outputs aligned with cnt
//                o_pend            - shadow waiting to be applied
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module clk_div_chan #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_div,
    input  logic [WIDTH-1:0] i_wr_high,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_pend
);

    localparam logic [WIDTH-1:0] c_RST_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] c_RST_HIGH = WIDTH'(DEFAULT_DIV / 2);

    logic [WIDTH-1:0] r_cnt, r_div, r_high, r_sh_div, r_sh_high;
    logic             r_pend, r_run, r_clk_out, r_tick;

    logic [WIDTH-1:0] w_cnt_nxt, w_div_nxt, w_high_nxt, w_sh_div_nxt, w_sh_high_nxt;
    logic             w_pend_nxt, w_wrap, w_start;

    // r_run remembers that the channel was enabled at the previous edge, so
    // a rising enable is treated as a period start.
    assign w_wrap  = r_run && (r_cnt == (r_div - WIDTH'(1)));
    assign w_start = i_en && (!r_run || i_sync || w_wrap);

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_div_nxt     = r_div;
        w_high_nxt    = r_high;
        w_sh_div_nxt  = r_sh_div;
        w_sh_high_nxt = r_sh_high;
        w_pend_nxt    = r_pend;

        if (!i_en) begin
            // Idle channel: no boundary will ever come, so a pending shadow
            // is copied straight across. A fresh write is parked first.
            w_cnt_nxt = '0;
            if (i_wr) begin
                w_sh_div_nxt  = i_wr_div;
                w_sh_high_nxt = i_wr_high;
                w_pend_nxt    = 1'b1;
            end else if (r_pend) begin
                w_div_nxt  = r_sh_div;
                w_high_nxt = r_sh_high;
                w_pend_nxt = 1'b0;
            end
        end else if (w_start) begin
            // Period start: a write landing on this same edge governs the
            // period that begins here, otherwise the shadow does.
            w_cnt_nxt = '0;
            if (i_wr) begin
                w_div_nxt     = i_wr_div;
                w_high_nxt    = i_wr_high;
                w_sh_div_nxt  = i_wr_div;
                w_sh_high_nxt = i_wr_high;
                w_pend_nxt    = 1'b0;
            end else if (r_pend) begin
                w_div_nxt  = r_sh_div;
                w_high_nxt = r_sh_high;
                w_pend_nxt = 1'b0;
            end
        end else begin
            w_cnt_nxt = r_cnt + WIDTH'(1);
            if (i_wr) begin
                w_sh_div_nxt  = i_wr_div;
                w_sh_high_nxt = i_wr_high;
                w_pend_nxt    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_cnt     <= '0;
            r_div     <= c_RST_DIV;
            r_high    <= c_RST_HIGH;
            r_sh_div  <= c_RST_DIV;
            r_sh_high <= c_RST_HIGH;
            r_pend    <= 1'b0;
            r_run     <= 1'b0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_high    <= w_high_nxt;
            r_sh_div  <= w_sh_div_nxt;
            r_sh_high <= w_sh_high_nxt;
            r_pend    <= w_pend_nxt;
            r_run     <= i_en;
            // Outputs are decoded from the next count so they line up with
            // r_cnt in the cycle they are visible.
            r_clk_out <= i_en && (w_cnt_nxt < w_high_nxt);
            r_tick    <= w_start;
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_pend    = r_pend;

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// ============================================================================
//  Module      : clk_div_multi
//  Description : Runtime-programmable N_CH-channel clock divider. Decodes
//                configuration writes, flags rejected writes and fans out to
//                one clk_div_chan per channel.
//  Ports       : clock_in, reset   - clock / synchronous active-high reset
//                en[N_CH]          - per-channel run enable
//                sync              - restart all enabled channels
//                wr_en/wr_ch/wr_div/wr_high - configuration write
//                clk_out/tick/pend [N_CH]   - per-channel status/outputs
//                wr_err            - one-cycle pulse on a rejected write
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                     clock_in,
    input  logic                     reset,
    input  logic [N_CH-1:0]          en,
    input  logic                     sync,
    input  logic                     wr_en,
    input  logic [ch_w(N_CH)-1:0]    wr_ch,
    input  logic [WIDTH-1:0]         wr_div,
    input  logic [WIDTH-1:0]         wr_high,
    output logic [N_CH-1:0]          clk_out,
    output logic [N_CH-1:0]          tick,
    output logic [N_CH-1:0]          pend,
    output logic                     wr_err
);

    logic             w_accept;
    logic [WIDTH-1:0] w_high_c;
    logic             r_wr_err;

    // wr_ch can address past the last channel when N_CH is not a power of
    // two; such writes are rejected along with too-short periods.
    assign w_accept = wr_en && (int'(wr_ch) < N_CH) && (wr_div >= WIDTH'(c_MIN_DIV));
    assign w_high_c = WIDTH'(clamp_high(32'(wr_div), 32'(wr_high)));

    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en && !w_accept;
        end
    end

    assign wr_err = r_wr_err;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        clk_div_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clock_in  (clock_in),
            .reset     (reset),
            .i_en      (en[i]),
            .i_sync    (sync),
            .i_wr      (w_accept && (int'(wr_ch) == i)),
            .i_wr_div  (wr_div),
            .i_wr_high (w_high_c),
            .o_clk_out (clk_out[i]),
            .o_tick    (tick[i]),
            .o_pend    (pend[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// ============================================================================
//  Module      : tb_clk_div_multi
//  Description : Directed self-checking bench for clk_div_multi (3 channels,
//                so channel index 3 is an out-of-range write target).
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_multi;

    localparam int c_N_CH  = 3;
    localparam int c_WIDTH = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [c_N_CH-1:0]   en;
    logic                sync;
    logic                wr_en;
    logic [1:0]          wr_ch;
    logic [c_WIDTH-1:0]  wr_div;
    logic [c_WIDTH-1:0]  wr_high;
    logic [c_N_CH-1:0]   clk_out;
    logic [c_N_CH-1:0]   tick;
    logic [c_N_CH-1:0]   pend;
    logic                wr_err;

    int n_checks = 0;
    int n_errors = 0;

    clk_div_multi #(
        .N_CH        (c_N_CH),
        .WIDTH       (c_WIDTH),
        .DEFAULT_DIV (2)
    ) dut (
        .clock_in (clk),
        .reset    (reset),
        .en       (en),
        .sync     (sync),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
        .wr_high  (wr_high),
        .clk_out  (clk_out),
        .tick     (tick),
        .pend     (pend),
        .wr_err   (wr_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        en      = '0;
        sync    = 1'b0;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_div  = '0;
        wr_high = '0;

        // Reset state
        cyc();
        cyc();
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_tick",    32'(tick),    32'd0);
        chk("rst_pend",    32'(pend),    32'd0);
        chk("rst_wr_err",  32'(wr_err),  32'd0);
        reset = 1'b0;
        cyc();
        chk("idle_clk_out", 32'(clk_out), 32'd0);

        // 1: ch0 with defaults D=2 H=1
        en = 3'b001;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("t1_clk0",  32'(clk_out[0]), 32'(k % 2 == 0));
            chk("t1_tick0", 32'(tick[0]),    32'(k % 2 == 0));
        end

        // 2: write D=5 H=2 to disabled ch1, then enable
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd5; wr_high = 16'd2;
        cyc();
        chk("t2_pend_set", 32'(pend[1]), 32'd1);
        chk("t2_no_err",   32'(wr_err),  32'd0);
        wr_en = 1'b0;
        cyc();
        chk("t2_pend_clr", 32'(pend[1]), 32'd0);
        en = 3'b011;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("t2_clk1",  32'(clk_out[1]), 32'((k % 5) < 2));
            chk("t2_tick1", 32'(tick[1]),    32'(k % 5 == 0));
        end

        // 3: mid-period rewrite to D=3 H=1; old period completes
        cyc();
        chk("t3_tick1_start", 32'(tick[1]), 32'd1);
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd3; wr_high = 16'd1;
        cyc();
        wr_en = 1'b0;
        chk("t3_pend_c1", 32'(pend[1]),    32'd1);
        chk("t3_clk_c1",  32'(clk_out[1]), 32'd1);
        for (int j = 2; j < 5; j++) begin
            cyc();
            chk("t3_pend_old", 32'(pend[1]),    32'd1);
            chk("t3_clk_old",  32'(clk_out[1]), 32'd0);
            chk("t3_tick_old", 32'(tick[1]),    32'd0);
        end
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("t3_pend_new", 32'(pend[1]),    32'd0);
            chk("t3_clk_new",  32'(clk_out[1]), 32'(k % 3 == 0));
            chk("t3_tick_new", 32'(tick[1]),    32'(k % 3 == 0));
        end

        // 4: rejected writes leave ch1 at D=3
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd1; wr_high = 16'd0;
        cyc();
        chk("t4_err_div",  32'(wr_err),     32'd1);
        chk("t4_pend_div", 32'(pend),       32'd0);
        chk("t4_tick_a",   32'(tick[1]),    32'd1);
        wr_ch = 2'd3; wr_div = 16'd7;
        cyc();
        chk("t4_err_ch",   32'(wr_err),     32'd1);
        chk("t4_pend_ch",  32'(pend),       32'd0);
        chk("t4_tick_b",   32'(tick[1]),    32'd0);
        wr_en = 1'b0;
        cyc();
        chk("t4_err_clr",  32'(wr_err),     32'd0);
        chk("t4_tick_c",   32'(tick[1]),    32'd0);
        cyc();
        chk("t4_tick_d",   32'(tick[1]),    32'd1);

        // 4b: clamp H=9 with D=4 on disabled ch2 -> H=3
        wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd4; wr_high = 16'd9;
        cyc();
        wr_en = 1'b0;
        chk("t4_clamp_pend", 32'(pend[2]), 32'd1);
        chk("t4_clamp_err",  32'(wr_err),  32'd0);
        cyc();
        chk("t4_clamp_pclr", 32'(pend[2]), 32'd0);
        en = 3'b111;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("t4_clk2",  32'(clk_out[2]), 32'((k % 4) < 3));
            chk("t4_tick2", 32'(tick[2]),    32'(k % 4 == 0));
        end

        // 5: ch0 D=4 H=2, ch2 D=6 H=3, then sync (with a ch1 write D=5 H=4)
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd4; wr_high = 16'd2;
        cyc();
        wr_ch = 2'd2; wr_div = 16'd6; wr_high = 16'd3;
        cyc();
        wr_en = 1'b0;
        for (int k = 0; k < 7; k++) cyc();
        chk("t5_pend_applied", 32'(pend), 32'd0);
        sync = 1'b1;
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd5; wr_high = 16'd4;
        for (int k = 0; k < 13; k++) begin
            cyc();
            sync  = 1'b0;
            wr_en = 1'b0;
            chk("t5_tick0", 32'(tick[0]),    32'(k % 4 == 0));
            chk("t5_tick2", 32'(tick[2]),    32'(k % 6 == 0));
            chk("t5_clk0",  32'(clk_out[0]), 32'((k % 4) < 2));
            chk("t5_clk2",  32'(clk_out[2]), 32'((k % 6) < 3));
            chk("t5_tick1", 32'(tick[1]),    32'(k % 5 == 0));
            chk("t5_clk1",  32'(clk_out[1]), 32'((k % 5) < 4));
            chk("t5_pend",  32'(pend),       32'd0);
        end

        // 6: reset mid-period with a pending shadow and a rejected write
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd8; wr_high = 16'd1;
        cyc();
        chk("t6_pre_pend", 32'(pend[0]), 32'd1);
        wr_div = 16'd0;
        reset  = 1'b1;
        cyc();
        chk("t6_rst_clk",  32'(clk_out), 32'd0);
        chk("t6_rst_tick", 32'(tick),    32'd0);
        chk("t6_rst_pend", 32'(pend),    32'd0);
        chk("t6_rst_err",  32'(wr_err),  32'd0);
        reset = 1'b0;
        wr_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t6_clk",  32'(clk_out), (k % 2 == 0) ? 32'd7 : 32'd0);
            chk("t6_tick", 32'(tick),    (k % 2 == 0) ? 32'd7 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
